// File: rtl/seg2opcode_pkg.sv
// Shared opcode / 7-segment encoding for the opcode display path (encoder and monitor).
package seg2opcode_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Segment bit order {a,b,c,d,e,f,g}, 1 = lit
  localparam logic [6:0] SEG_A_ADD = 7'b1110111;
  localparam logic [6:0] SEG_L_LW  = 7'b0001110;
  localparam logic [6:0] SEG_S_SW  = 7'b1011011;
  localparam logic [6:0] SEG_J_J   = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {ST_SETTLE, ST_LOCKED} mon_state_e;

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [1:0] op;
  } seg_dec_t;

  // Map a segment pattern back to its opcode; blank and illegal are flagged separately.
  function automatic seg_dec_t seg_decode(input logic [6:0] s);
    seg_dec_t d;
    d = '{legal: 1'b1, is_blank: 1'b0, op: OP_ADD};
    case (s)
      SEG_A_ADD: d.op = OP_ADD;
      SEG_L_LW:  d.op = OP_LW;
      SEG_S_SW:  d.op = OP_SW;
      SEG_J_J:   d.op = OP_J;
      SEG_BLANK: begin d.legal = 1'b0; d.is_blank = 1'b1; end
      default:   d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg2opcode_monitor_seg_stabilizer.sv
// Input register plus run-length counter: flags when the sampled pattern has been unchanged long enough.
module seg_stabilizer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [6:0] seg_q,
  output logic       same,
  output logic       stable
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_q_q, seg_q_d;
  logic [7:0] stab_cnt_q, stab_cnt_d;

  assign seg_q  = seg_q_q;
  assign same   = (seg == seg_q_q);
  assign stable = same && (stab_cnt_q == CNT_MAX);

  // Count edges the pattern held; restart on any change, park at the threshold
  always_comb begin
    seg_q_d    = seg;
    stab_cnt_d = stab_cnt_q;
    if (!same)                      stab_cnt_d = '0;
    else if (stab_cnt_q != CNT_MAX) stab_cnt_d = stab_cnt_q + 8'd1;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q_q    <= '0;
      stab_cnt_q <= '0;
    end else begin
      seg_q_q    <= seg_q_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

endmodule

// File: rtl/seg2opcode_monitor.sv
// Receive-side opcode-digit monitor: accept each stable pattern once, decode it, log per-opcode and error counts.
module seg2opcode_monitor
  import seg2opcode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [6:0]       seg,
  input  logic             clr_counts,
  output logic             opcode_valid,
  output logic [1:0]       opcode,
  output logic             invalid,
  output logic             blank,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_lw,
  output logic [CNT_W-1:0] cnt_sw,
  output logic [CNT_W-1:0] cnt_j,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int ERR_IDX = 4;

  logic [6:0] seg_q;
  logic       same, stable, accept;
  seg_dec_t   dec;

  mon_state_e            state_q, state_d;
  logic [1:0]            opcode_q, opcode_d;
  logic                  opcode_valid_q, opcode_valid_d;
  logic                  invalid_q, invalid_d;
  logic                  blank_q, blank_d;
  logic [4:0][CNT_W-1:0] cnt_q, cnt_d;   // [0..3] per opcode, [4] illegal patterns

  seg_stabilizer #(.STABLE_CYCLES(STABLE_CYCLES)) u_stab (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg    (seg),
    .seg_q  (seg_q),
    .same   (same),
    .stable (stable)
  );

  assign dec    = seg_decode(seg_q);
  assign accept = en && (state_q == ST_SETTLE) && stable;

  // Next state, decode of the accepted pattern, saturating counters with clear priority
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    blank_d        = blank_q;
    opcode_valid_d = 1'b0;
    invalid_d      = 1'b0;
    cnt_d          = cnt_q;

    if (!en)                                   state_d = ST_SETTLE;
    else if (state_q == ST_SETTLE && stable)   state_d = ST_LOCKED;
    else if (state_q == ST_LOCKED && !same)    state_d = ST_SETTLE;

    if (accept) begin
      if (dec.legal) begin
        opcode_d       = dec.op;
        opcode_valid_d = 1'b1;
        blank_d        = 1'b0;
        if (cnt_q[{1'b0, dec.op}] != '1)
          cnt_d[{1'b0, dec.op}] = cnt_q[{1'b0, dec.op}] + CNT_W'(1);
      end else if (dec.is_blank) begin
        blank_d = 1'b1;
      end else begin
        invalid_d = 1'b1;
        blank_d   = 1'b0;
        if (cnt_q[ERR_IDX] != '1) cnt_d[ERR_IDX] = cnt_q[ERR_IDX] + CNT_W'(1);
      end
    end

    if (clr_counts) cnt_d = '0;
  end

  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_SETTLE;
      opcode_q       <= OP_ADD;
      opcode_valid_q <= 1'b0;
      invalid_q      <= 1'b0;
      blank_q        <= 1'b1;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      opcode_valid_q <= opcode_valid_d;
      invalid_q      <= invalid_d;
      blank_q        <= blank_d;
      cnt_q          <= cnt_d;
    end
  end

  assign opcode_valid = opcode_valid_q;
  assign opcode       = opcode_q;
  assign invalid      = invalid_q;
  assign blank        = blank_q;
  assign cnt_add      = cnt_q[0];
  assign cnt_lw       = cnt_q[1];
  assign cnt_sw       = cnt_q[2];
  assign cnt_j        = cnt_q[3];
  assign err_cnt      = cnt_q[ERR_IDX];

endmodule
